// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM: sequences fetch/decode/execute/writeback,
// drives datapath selects, counts retired instructions and latches a sticky trap.
module multicycle_controller #(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned EN_JAL        = 1,
  parameter int unsigned EN_ITYPE      = 1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ImmSrc,
  output logic             RegWrite,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegal,
  output logic [3:0]       state
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10,
    StTrap     = 4'd11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             illegal_q;
  logic             rdy;

  // Without the handshake, memory is assumed to complete in one cycle.
  assign rdy = mem_ready | (MEM_HANDSHAKE == 0);

  // Next-state decode and retire strobe (retire marks the return to fetch).
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch:  if (rdy) state_d = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecR;
          OpItype:         state_d = (EN_ITYPE != 0) ? StExecI : StTrap;
          OpBranch:        state_d = StBeq;
          OpJal:           state_d = (EN_JAL != 0) ? StJal : StTrap;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr:  state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead: if (rdy) state_d = StMemWb;
      StMemWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWrite: begin
        if (rdy) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExecR, StExecI, StJal: state_d = StAluWb;
      StAluWb, StBeq: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase
  end

  // State, retired-instruction counter and sticky trap flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
      if (state_d == StTrap) illegal_q <= 1'b1;
    end
  end

  // Per-state datapath controls; fetch gates its enables on rdy so a stall
  // never produces a spurious PC/IR write.
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    RegWrite  = 1'b0;
    case (state_q)
      StFetch: begin
        IRWrite   = rdy;
        PCWrite   = rdy;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StMemRead: AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      StExecR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      StExecI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      StAluWb: RegWrite = 1'b1;
      StBeq: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = zero;
      end
      StJal: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (op)
      OpStore:  ImmSrc = 2'b01;
      OpBranch: ImmSrc = 2'b10;
      OpJal:    ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  assign instret = instret_q;
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: an instruction-level model emits per-cycle expectations,
// a negedge monitor pops and compares them against the controller.
`timescale 1ns/1ps
module tb_multicycle_controller;

  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpBeq = 7'b1100011;
  localparam logic [6:0] OpJal = 7'b1101111;
  localparam logic [6:0] OpBad = 7'b1111111;

  localparam int SF = 0, SD = 1, SMA = 2, SMR = 3, SMWB = 4, SMW = 5;
  localparam int SER = 6, SEI = 7, SWB = 8, SBEQ = 9, SJ = 10, ST = 11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  op = 7'd0;
  logic        zero = 1'b0, mem_ready = 1'b0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, retire, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [31:0] instret;
  logic [3:0]  state;

  logic        reset2 = 1'b1;
  logic [6:0]  op2 = 7'd0;
  logic        zero2 = 1'b0, mr2 = 1'b0;
  logic        PCWrite2, AdrSrc2, MemWrite2, IRWrite2, RegWrite2, retire2, illegal2;
  logic [1:0]  ResultSrc2, ALUSrcA2, ALUSrcB2, ALUOp2, ImmSrc2;
  logic [3:0]  instret2;
  logic [3:0]  state2;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .retire(retire), .instret(instret),
    .illegal(illegal), .state(state)
  );

  multicycle_controller #(
    .MEM_HANDSHAKE(0), .EN_JAL(0), .EN_ITYPE(0), .CNT_W(4)
  ) dut2 (
    .clk(clk), .reset(reset2), .op(op2), .zero(zero2), .mem_ready(mr2),
    .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .MemWrite(MemWrite2), .IRWrite(IRWrite2),
    .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ALUOp(ALUOp2),
    .ImmSrc(ImmSrc2), .RegWrite(RegWrite2), .retire(retire2), .instret(instret2),
    .illegal(illegal2), .state(state2)
  );

  always #5 clk = ~clk;

  logic [15:0] act_ctl, act_ctl2;
  assign act_ctl  = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                     ALUOp, ImmSrc, RegWrite, retire};
  assign act_ctl2 = {PCWrite2, AdrSrc2, MemWrite2, IRWrite2, ResultSrc2, ALUSrcA2,
                     ALUSrcB2, ALUOp2, ImmSrc2, RegWrite2, retire2};

  typedef struct {
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [31:0] cnt;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   model_cnt = 0;
  bit   model_ill = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit rb();
    return $urandom_range(0, 1) != 0;
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == OpSw) return 2'b01;
    if (o == OpBeq) return 2'b10;
    if (o == OpJal) return 2'b11;
    return 2'b00;
  endfunction

  // Control table by state name, packed like act_ctl.
  function automatic logic [15:0] exp_ctl(input int st, input bit mr, input bit z,
                                          input logic [6:0] o, input bit ret);
    logic pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, aop;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; rs = 0; sa = 0; sb = 0; aop = 0;
    case (st)
      SF:   begin irw = mr; pcw = mr; sb = 2'b10; rs = 2'b10; end
      SD:   begin sa = 2'b01; sb = 2'b01; end
      SMA:  begin sa = 2'b10; sb = 2'b01; end
      SMR:  adr = 1;
      SMWB: begin rs = 2'b01; rw = 1; end
      SMW:  begin adr = 1; mw = 1; end
      SER:  begin sa = 2'b10; aop = 2'b10; end
      SEI:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      SWB:  rw = 1;
      SBEQ: begin sa = 2'b10; aop = 2'b01; pcw = z; end
      SJ:   begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, rs, sa, sb, aop, imm_of(o), rw, ret};
  endfunction

  // Drive one cycle of inputs and queue what the controller must show.
  task automatic emit(input int st, input bit mr, input bit z, input logic [6:0] o,
                      input bit ret);
    exp_t e;
    op = o; zero = z; mem_ready = mr;
    e.st  = 4'(st);
    e.ctl = exp_ctl(st, mr, z, o, ret);
    e.cnt = 32'(model_cnt);
    e.ill = model_ill;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (ret) model_cnt++;
  endtask

  // One whole instruction: kind 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal.
  task automatic instr(input int kind, input int fst, input int mst, input bit z);
    logic [6:0] o;
    case (kind)
      0: o = OpLw;
      1: o = OpSw;
      2: o = OpR;
      3: o = OpI;
      4: o = OpBeq;
      default: o = OpJal;
    endcase
    repeat (fst) emit(SF, 0, rb(), o, 0);
    emit(SF, 1, rb(), o, 0);
    emit(SD, rb(), rb(), o, 0);
    case (kind)
      0: begin
        emit(SMA, rb(), rb(), o, 0);
        repeat (mst) emit(SMR, 0, rb(), o, 0);
        emit(SMR, 1, rb(), o, 0);
        emit(SMWB, rb(), rb(), o, 1);
      end
      1: begin
        emit(SMA, rb(), rb(), o, 0);
        repeat (mst) emit(SMW, 0, rb(), o, 0);
        emit(SMW, 1, rb(), o, 1);
      end
      2: begin emit(SER, rb(), rb(), o, 0); emit(SWB, rb(), rb(), o, 1); end
      3: begin emit(SEI, rb(), rb(), o, 0); emit(SWB, rb(), rb(), o, 1); end
      4: emit(SBEQ, rb(), z, o, 1);
      default: begin emit(SJ, rb(), rb(), o, 0); emit(SWB, rb(), rb(), o, 1); end
    endcase
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("state", 64'(state), 64'(mon_e.st));
      check("controls", 64'(act_ctl), 64'(mon_e.ctl));
      check("instret", 64'(instret), 64'(mon_e.cnt));
      check("illegal", 64'(illegal), 64'(mon_e.ill));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted finish");
    $fatal(1);
  end

  initial begin
    // Reset state is visible without any clock edge.
    mem_ready = 1'b1; op = OpLw;
    #3;
    check("rst_state", 64'(state), 64'(0));
    check("rst_instret", 64'(instret), 64'(0));
    check("rst_illegal", 64'(illegal), 64'(0));
    check("rst_ctl", 64'(act_ctl), 64'(exp_ctl(SF, 1, 0, OpLw, 0)));
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset pulse between edges while stalled in MEMREAD.
    emit(SF, 1, 0, OpLw, 0);
    emit(SD, 1, 0, OpLw, 0);
    emit(SMA, 1, 0, OpLw, 0);
    emit(SMR, 0, 0, OpLw, 0);
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("memread_rst_state", 64'(state), 64'(0));
    check("memread_rst_instret", 64'(instret), 64'(0));
    #1;
    reset = 1'b0;
    model_cnt = 0;

    // Reset during a stalled MEMWRITE must not retire even with mem_ready high.
    emit(SF, 1, 0, OpSw, 0);
    emit(SD, 1, 0, OpSw, 0);
    emit(SMA, 1, 0, OpSw, 0);
    emit(SMW, 0, 0, OpSw, 0);
    emit(SMW, 0, 0, OpSw, 0);
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("memwrite_rst_state", 64'(state), 64'(0));
    check("memwrite_rst_retire", 64'(retire), 64'(0));
    check("memwrite_rst_memwrite", 64'(MemWrite), 64'(0));
    check("memwrite_rst_regwrite", 64'(RegWrite), 64'(0));
    check("memwrite_rst_instret", 64'(instret), 64'(0));
    #1;
    reset = 1'b0;
    model_cnt = 0;

    // Directed: lw, sw with 3 stalls, beq taken then not taken.
    instr(0, 0, 0, 0);
    instr(1, 0, 3, 0);
    instr(4, 0, 0, 1);
    instr(4, 0, 0, 0);

    // Random instruction stream with random fetch/memory stalls.
    for (int i = 0; i < 250; i++) begin
      instr(int'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
            int'($urandom_range(0, 2)), rb());
    end

    // Undefined opcode traps and sticks until reset.
    emit(SF, 1, 0, OpBad, 0);
    emit(SD, rb(), rb(), OpBad, 0);
    model_ill = 1'b1;
    repeat (4) emit(ST, rb(), rb(), OpBad, 0);
    reset = 1'b1;
    #1;
    check("trap_rst_state", 64'(state), 64'(0));
    check("trap_rst_illegal", 64'(illegal), 64'(0));
    check("trap_rst_instret", 64'(instret), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    model_ill = 1'b0;
    model_cnt = 0;
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    // Reduced configuration: no handshake, no jal/I-type, 4-bit counter.
    op2 = OpR; mr2 = 1'b0;
    @(posedge clk); #1;
    reset2 = 1'b0;
    check("nohs_fetch_irwrite", 64'(IRWrite2), 64'(1));
    for (int i = 0; i < 16; i++) begin
      check("r_fetch", 64'(state2), 64'(SF));
      @(posedge clk); #1;
      check("r_decode", 64'(state2), 64'(SD));
      @(posedge clk); #1;
      check("r_exec", 64'(state2), 64'(SER));
      @(posedge clk); #1;
      check("r_aluwb", 64'(state2), 64'(SWB));
      check("r_retire", 64'(retire2), 64'(1));
      @(posedge clk); #1;
      check("r_instret_wrap", 64'(instret2), 64'((i + 1) % 16));
    end

    op2 = OpJal;
    @(posedge clk); #1;
    check("jal_decode", 64'(state2), 64'(SD));
    @(posedge clk); #1;
    check("jal_trap", 64'(state2), 64'(ST));
    check("jal_illegal", 64'(illegal2), 64'(1));
    check("jal_trap_ctl", 64'(act_ctl2 & 16'hFFF3), 64'(0));
    mr2 = 1'b1;
    @(posedge clk); #1;
    check("jal_trap_stays", 64'(state2), 64'(ST));
    check("jal_trap_ctl2", 64'(act_ctl2 & 16'hFFF3), 64'(0));
    reset2 = 1'b1;
    #1;
    check("jal_rst_state", 64'(state2), 64'(0));
    check("jal_rst_illegal", 64'(illegal2), 64'(0));
    @(posedge clk); #1;
    reset2 = 1'b0;

    op2 = OpI;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("itype_trap", 64'(state2), 64'(ST));
    check("itype_illegal", 64'(illegal2), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
